radix4_otf_converter: RTL and testbench

Radix-4 on-the-fly converter: the receiving end of the signed-digit stream produced by the radix-4 selection stage (digits p_j ∈ {-3..3}, 3-bit two's complement, most significant digit first). It accumulates `no_of_digits` digits into a conventional two's-complement integer using the carry-free Q/QM concatenation scheme. It then presents the result with a one-cycle valid pulse, for use downstream of the online multiplier/divider datapath.

---
 rtl/radix4_otf_converter.sv | 112 +++++++++++
 tb/tb_radix4_otf_converter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/radix4_otf_converter.sv
// Radix-4 on-the-fly converter: signed digits in, MSD first, two's complement out.
// Q/QM are built by 2-bit appends only, so no carry chain sits on the digit path.
module radix4_otf_converter #(
  parameter int no_of_digits = 4,
  parameter int radix_bits = 3,
  localparam int W = 2*no_of_digits+1,
  localparam int CW = $clog2(no_of_digits+1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  digit_valid,
  input  logic [radix_bits-1:0] p_j,
  output logic [W-1:0]          result,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  digit_err
);

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t state;

  logic [W-1:0]  q;
  logic [W-1:0]  qm;
  logic [CW-1:0] cnt;

  logic [W-1:0]          q_base;
  logic [W-1:0]          qm_base;
  logic [CW-1:0]         cnt_base;
  logic [CW-1:0]         cnt_inc;
  logic [radix_bits-1:0] d;
  logic [1:0]            dl;
  logic [1:0]            q_tail;
  logic [1:0]            qm_tail;
  logic [W-1:0]          q_src;
  logic [W-1:0]          qm_src;
  logic [W-1:0]          q_nxt;
  logic [W-1:0]          qm_nxt;
  logic                  accept;
  logic                  illegal;
  logic                  neg;
  logic                  pos;
  logic                  last;

  always_comb begin
    q_base   = start ? '0 : q;
    qm_base  = start ? '1 : qm;
    cnt_base = start ? '0 : cnt;
    cnt_inc  = cnt_base + CW'(1);

    accept  = digit_valid && (start || state == CONV);
    illegal = p_j == radix_bits'(3'b100);
    d       = illegal ? '0 : p_j;
    dl      = d[1:0];
    neg     = d[radix_bits-1];
    pos     = !neg && (dl != 2'd0);

    // 4+p and p mod 4 agree; p-1 and 3+p also agree mod 4
    q_tail  = dl;
    qm_tail = dl - 2'd1;

    q_src  = neg ? qm_base : q_base;
    qm_src = pos ? q_base : qm_base;
    q_nxt  = (q_src << 2) | W'(q_tail);
    qm_nxt = (qm_src << 2) | W'(qm_tail);

    last = accept && (cnt_inc == CW'(no_of_digits));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      q            <= '0;
      qm           <= '1;
      cnt          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      digit_err    <= 1'b0;
    end else begin
      if (accept) begin
        q   <= q_nxt;
        qm  <= qm_nxt;
        cnt <= cnt_inc;
      end else if (start) begin
        q   <= '0;
        qm  <= '1;
        cnt <= '0;
      end

      if (last)
        state <= IDLE;
      else if (start)
        state <= CONV;

      busy         <= !last && (start || busy);
      result_valid <= last;
      if (last)
        result <= q_nxt;

      if (start)
        digit_err <= accept && illegal;
      else if (accept && illegal)
        digit_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_radix4_otf_converter.sv
// Bench for radix4_otf_converter: directed runs plus random traffic
// checked against an integer-accumulation model of the digit stream.
module tb_radix4_otf_converter;

  localparam int N = 4;
  localparam int W = 2*N+1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         digit_valid = 1'b0;
  logic [2:0]   p_j = 3'd0;
  logic [W-1:0] result;
  logic         result_valid;
  logic         busy;
  logic         digit_err;

  radix4_otf_converter #(
    .no_of_digits(N),
    .radix_bits(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .digit_valid(digit_valid),
    .p_j(p_j),
    .result(result),
    .result_valid(result_valid),
    .busy(busy),
    .digit_err(digit_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  bit           m_active = 0;
  int           m_cnt = 0;
  int           m_val = 0;
  bit           m_err = 0;
  logic [W-1:0] m_res = '0;
  bit           m_rv = 0;
  int           rv_count = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dval(input logic [2:0] p);
    logic signed [2:0] ps;
    ps = p;
    if (p == 3'b100) return 0;
    return int'(ps);
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_cnt = 0;
    m_val = 0;
    m_err = 0;
    m_res = '0;
    m_rv = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_result"}, 32'(result), 32'(m_res));
    chk({tag, "_valid"}, 32'(result_valid), 32'(m_rv));
    chk({tag, "_busy"}, 32'(busy), 32'(m_active));
    chk({tag, "_err"}, 32'(digit_err), 32'(m_err));
  endtask

  task automatic do_cycle(input bit s, input bit dv, input logic [2:0] p,
                          input string tag);
    start = s;
    digit_valid = dv;
    p_j = p;
    @(posedge clk);
    #1;
    if (s) begin
      m_active = 1;
      m_cnt = 0;
      m_val = 0;
      m_err = 0;
    end
    if (m_active && dv) begin
      m_val = m_val*4 + dval(p);
      m_cnt++;
      if (p == 3'b100) m_err = 1;
    end
    m_rv = 0;
    if (m_active && m_cnt == N) begin
      m_res = W'(m_val);
      m_rv = 1;
      m_active = 0;
    end
    if (result_valid) rv_count++;
    check_all(tag);
    start = 1'b0;
    digit_valid = 1'b0;
  endtask

  task automatic conv4(input int a, input int b, input int c, input int d,
                       input int gap, input string tag);
    int dg[4];
    dg = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      do_cycle(i == 0, 1'b1, 3'(dg[i]), tag);
      if (i < 3)
        for (int g = 0; g < gap; g++) do_cycle(1'b0, 1'b0, 3'd0, tag);
    end
  endtask

  task automatic pulse_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    #12;
    model_reset();
    check_all("reset");
    #1 reset_n = 1'b1;
    #1;

    conv4(1, 0, 0, 0, 0, "tp64");
    chk("tp64_lit", 32'(result), 32'h040);
    chk("tp64_pulse", 32'(result_valid), 32'd1);
    do_cycle(1'b0, 1'b0, 3'd0, "tp64_after");
    chk("tp64_onepulse", 32'(result_valid), 32'd0);

    conv4(3, 3, 3, 3, 0, "tp255");
    chk("tp255_lit", 32'(result), 32'h0FF);
    conv4(-3, -3, -3, -3, 0, "tpm255");
    chk("tpm255_lit", 32'(result), 32'h101);
    do_cycle(1'b0, 1'b0, 3'd0, "idle");

    rv_count = 0;
    conv4(1, -3, 2, -1, 2, "tp23");
    chk("tp23_lit", 32'(result), 32'h017);
    do_cycle(1'b0, 1'b0, 3'd0, "tp23_after");
    chk("tp23_pulses", 32'(rv_count), 32'd1);

    rv_count = 0;
    do_cycle(1'b1, 1'b1, 3'd2, "abort");
    do_cycle(1'b0, 1'b1, 3'd2, "abort");
    conv4(0, 0, 0, -1, 0, "abort");
    chk("abort_lit", 32'(result), 32'h1FF);
    chk("abort_pulses", 32'(rv_count), 32'd1);
    conv4(4, 1, 0, 0, 0, "illegal");
    chk("illegal_lit", 32'(result), 32'h010);
    chk("illegal_err", 32'(digit_err), 32'd1);
    do_cycle(1'b1, 1'b0, 3'd0, "errclr");
    chk("errclr_lit", 32'(digit_err), 32'd0);
    do_cycle(1'b0, 1'b1, 3'd1, "errclr");
    do_cycle(1'b0, 1'b1, 3'd4, "errclr");

    do_cycle(1'b1, 1'b1, 3'd1, "rst_mid");
    do_cycle(1'b0, 1'b1, 3'd1, "rst_mid");
    pulse_reset("rst_mid_async");
    chk("rst_mid_lit", 32'(result), 32'd0);
    conv4(0, 0, 0, 1, 0, "after_rst");
    chk("after_rst_lit", 32'(result), 32'h001);
    do_cycle(1'b0, 1'b0, 3'd0, "idle");

    for (int i = 0; i < 6; i++)
      do_cycle(1'b0, 1'b1, 3'($urandom_range(0, 7)), "idle_dv");
    chk("idle_dv_lit", 32'(result), 32'h001);

    for (int i = 0; i < 3000; i++) begin
      bit s;
      bit dv;
      logic [2:0] p;
      s  = ($urandom_range(0, 99) < (m_active ? 4 : 30));
      dv = ($urandom_range(0, 99) < 65);
      p  = ($urandom_range(0, 49) == 0) ? 3'b100 :
           3'(int'($urandom_range(0, 6)) - 3);
      do_cycle(s, dv, p, "rand");
      if ($urandom_range(0, 299) == 0) pulse_reset("rand_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
